// File: rtl/mem_arbiter_if.sv
// CPU-side and RAM-side signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          ihit;
  logic [DW-1:0] iload;
  logic          dhit;
  logic [DW-1:0] dload;
  logic          mem_err;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, mem_err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, mem_err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto a single-ported RAM,
// with registered hit pulses and a watchdog that aborts hung accesses.
//
// state | meaning
// IDLE  | no access in flight; accepts a request unless a hit pulsed this cycle
// DACC  | data access driving the RAM, waiting for ACCESS/ERROR/timeout
// IACC  | instruction fetch driving the RAM, waiting for ACCESS/ERROR/timeout
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  bus
);
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          ihit_q, dhit_q, err_q, ren_q, wen_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] store_q, iload_q, dload_q;
  logic          acc_ok, acc_fail, acc_done;

  // ACCESS wins over a coincident watchdog expiry
  assign acc_ok   = (bus.ramstate == RAM_ACCESS);
  assign acc_fail = !acc_ok && ((bus.ramstate == RAM_ERROR) || (wait_cnt == CNT_LAST));
  assign acc_done = acc_ok || acc_fail;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      err_q    <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          // the requester drops its request on the hit edge, so skip that cycle
          if (!(ihit_q || dhit_q)) begin
            if (bus.dREN || bus.dWEN) begin
              state   <= DACC;
              addr_q  <= bus.daddr;
              store_q <= bus.dstore;
              ren_q   <= !bus.dWEN;
              wen_q   <= bus.dWEN;
            end else if (bus.iREN) begin
              state  <= IACC;
              addr_q <= bus.iaddr;
              ren_q  <= 1'b1;
              wen_q  <= 1'b0;
            end
          end
        end
        DACC, IACC: begin
          if (acc_done) begin
            state    <= IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            wait_cnt <= '0;
            err_q    <= acc_fail;
            if (state == DACC) begin
              dhit_q <= 1'b1;
              if (acc_fail)    dload_q <= '0;
              else if (!wen_q) dload_q <= bus.ramload;
            end else begin
              ihit_q  <= 1'b1;
              iload_q <= acc_fail ? '0 : bus.ramload;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
          wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.mem_err  = err_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a word-memory reference model with latency arithmetic.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_dload = '0;
  logic [DW-1:0] exp_iload = '0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // One access: request already applied, FSM idle. Plays the RAM for busy
  // cycles then fin, and checks latency, strobes, hit, error, load and bubble.
  task automatic serve(input bit is_d, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int busy,
                       input logic [1:0] fin, input string name);
    int            j_end, hit_n, j;
    bit            exp_err, strobe_ok;
    logic [DW-1:0] exp_load;
    logic [1:0]    exp_hits;
    j_end     = (busy <= TO - 1) ? busy : TO - 1;
    exp_err   = (busy > TO - 1) || (fin == ERR);
    hit_n     = -1;
    j         = 0;
    strobe_ok = 1'b1;
    for (int n = 1; n <= TO + 6; n++) begin
      @(posedge CLK); #1;
      if (bus.ihit || bus.dhit) begin
        hit_n = n;
        break;
      end
      if (bus.ramREN !== !wr || bus.ramWEN !== wr || bus.ramaddr !== addr ||
          (wr && bus.ramstore !== wdata))
        strobe_ok = 1'b0;
      bus.ramstate = (j < busy) ? BUSY : fin;
      bus.ramload  = $urandom;
      if (bus.ramstate == ACC) begin
        if (bus.ramWEN) ram_mem[bus.ramaddr[3:0]] = bus.ramstore;
        else            bus.ramload = ram_mem[bus.ramaddr[3:0]];
      end
      j++;
    end
    bus.ramstate = FREE;

    if (exp_err)  exp_load = '0;
    else if (wr)  exp_load = exp_dload;
    else          exp_load = ref_mem[addr[3:0]];
    if (!exp_err && wr) ref_mem[addr[3:0]] = wdata;
    if (is_d) exp_dload = exp_load;
    else      exp_iload = exp_load;
    exp_hits = is_d ? 2'b10 : 2'b01;

    checks++;
    if (hit_n !== j_end + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, hit_n, j_end + 2);
    end
    checks++;
    if (strobe_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s ram_drive: strobe/addr/store wrong during access (addr %h)", name, addr);
    end
    checks++;
    if ({bus.dhit, bus.ihit} !== exp_hits) begin
      errors++;
      $display("FAIL %s hits: got dhit,ihit=%b expected %b", name, {bus.dhit, bus.ihit}, exp_hits);
    end
    checks++;
    if (bus.mem_err !== exp_err) begin
      errors++;
      $display("FAIL %s mem_err: got %b expected %b", name, bus.mem_err, exp_err);
    end
    checks++;
    if ((is_d ? bus.dload : bus.iload) !== exp_load) begin
      errors++;
      $display("FAIL %s load: got %h expected %h", name, is_d ? bus.dload : bus.iload, exp_load);
    end

    if (is_d) begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end else begin
      bus.iREN = 1'b0;
    end
    @(posedge CLK); #1;
    checks++;
    if ({bus.ihit, bus.dhit, bus.mem_err, bus.ramREN, bus.ramWEN} !== 5'b0 ||
        bus.dload !== exp_dload || bus.iload !== exp_iload) begin
      errors++;
      $display("FAIL %s bubble: got ih,dh,err,ren,wen=%b dload=%h iload=%h expected 00000 %h %h",
               name, {bus.ihit, bus.dhit, bus.mem_err, bus.ramREN, bus.ramWEN},
               bus.dload, bus.iload, exp_dload, exp_iload);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.ihit, bus.dhit, bus.mem_err, bus.ramREN, bus.ramWEN} !== 5'b0 ||
        bus.iload !== '0 || bus.dload !== '0 || bus.ramaddr !== '0 || bus.ramstore !== '0) begin
      errors++;
      $display("FAIL %s: got ih,dh,err,ren,wen=%b iload=%h dload=%h addr=%h store=%h expected all 0",
               name, {bus.ihit, bus.dhit, bus.mem_err, bus.ramREN, bus.ramWEN},
               bus.iload, bus.dload, bus.ramaddr, bus.ramstore);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_read_basic();
    ram_mem[0] = 32'hDEAD_BEEF;
    ref_mem[0] = 32'hDEAD_BEEF;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    serve(1'b1, 1'b0, 32'h40, '0, 0, ACC, "read_basic");
  endtask

  task automatic test_back_to_back();
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h104;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h45;
    bus.dstore = 32'h1234;
    serve(1'b1, 1'b1, 32'h45, 32'h1234, 0, ACC, "b2b_write");
    serve(1'b0, 1'b0, 32'h104, '0, 0, ACC, "b2b_fetch");
    bus.dREN  = 1'b1;
    bus.daddr = 32'h45;
    serve(1'b1, 1'b0, 32'h45, '0, 1, ACC, "b2b_readback");
  endtask

  task automatic test_busy_fetch();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'hA5A5_0003;
    serve(1'b0, 1'b0, 32'hA5A5_0003, '0, 5, ACC, "busy_fetch");
  endtask

  task automatic test_timeout();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h0000_0123;
    serve(1'b1, 1'b0, 32'h0000_0123, '0, 20, ACC, "timeout");
    bus.dREN  = 1'b1;
    bus.daddr = 32'h0000_0124;
    serve(1'b1, 1'b0, 32'h0000_0124, '0, TO - 1, ACC, "timeout_edge_ok");
  endtask

  task automatic test_error();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h0000_0206;
    serve(1'b0, 1'b0, 32'h0000_0206, '0, 2, ERR, "ierror");
  endtask

  task automatic test_reset_mid();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h77;
    @(posedge CLK); #1;
    bus.ramstate = BUSY;
    @(posedge CLK); #1;
    #2 nRST = 1'b0;
    #1;
    check_all_zero("reset_mid");
    exp_dload = '0;
    exp_iload = '0;
    bus.ramstate = FREE;
    #1 nRST = 1'b1;
    serve(1'b1, 1'b0, 32'h77, '0, 1, ACC, "reset_restart");
  endtask

  task automatic test_random();
    int            pat, b1, b2;
    bit            wr;
    logic [AW-1:0] da, ia;
    logic [DW-1:0] ds;
    logic [1:0]    f1, f2;
    for (int k = 0; k < 40; k++) begin
      pat = $urandom_range(0, 3);
      da  = $urandom;
      ia  = $urandom;
      ds  = $urandom;
      b1  = $urandom_range(0, 10);
      b2  = $urandom_range(0, 10);
      f1  = ($urandom_range(0, 4) == 0) ? ERR : ACC;
      f2  = ($urandom_range(0, 4) == 0) ? ERR : ACC;
      wr  = $urandom_range(0, 1);
      case (pat)
        0: begin
          bus.dREN = 1'b1; bus.daddr = da;
          serve(1'b1, 1'b0, da, '0, b1, f1, "rand_dread");
        end
        1: begin
          bus.dWEN = 1'b1; bus.dREN = wr; bus.daddr = da; bus.dstore = ds;
          serve(1'b1, 1'b1, da, ds, b1, f1, "rand_dwrite");
        end
        2: begin
          bus.iREN = 1'b1; bus.iaddr = ia;
          serve(1'b0, 1'b0, ia, '0, b1, f1, "rand_fetch");
        end
        default: begin
          bus.iREN = 1'b1; bus.iaddr = ia;
          bus.dWEN = wr; bus.dREN = !wr; bus.daddr = da; bus.dstore = ds;
          serve(1'b1, wr, da, ds, b1, f1, "rand_both_d");
          serve(1'b0, 1'b0, ia, '0, b2, f2, "rand_both_i");
        end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_busy_fetch();
    test_timeout();
    test_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
